// File: rtl/usr_pkg.sv
// usr_pkg
//   Shared definitions for the universal shift register:
//   - operation-select encodings driven on the 3-bit mode input
//   - FSM state encoding for the burst engine
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROTL = 3'b100;
   localparam logic [2:0] MODE_ROTR = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_RSVD = 3'b111;   // behaves as HOLD

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

endpackage

// File: rtl/usr_shift_unit.sv
// usr_shift_unit
//   Purely combinational next-value generator for the shift register.
//   Ports:
//     q           in  WIDTH  current register contents
//     mode        in  3      operation select (usr_pkg MODE_*)
//     ser_in_lsb  in  1      bit shifted into bit 0 on SHL
//     ser_in_msb  in  1      bit shifted into bit WIDTH-1 on SHR
//     parallel_in in  WIDTH  value taken on LOAD
//     next_q      out WIDTH  register value after the operation
module usr_shift_unit
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       mode,
   input  logic             ser_in_lsb,
   input  logic             ser_in_msb,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] next_q
);

   always_comb begin
      next_q = q;
      case (mode)
         MODE_SHL:  next_q = {q[WIDTH-2:0], ser_in_lsb};
         MODE_SHR:  next_q = {ser_in_msb, q[WIDTH-1:1]};
         MODE_LOAD: next_q = parallel_in;
         MODE_ROTL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROTR: next_q = {q[0], q[WIDTH-1:1]};
         MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
         default:   next_q = q;   // HOLD and reserved encoding
      endcase
   end

endmodule

// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n
//   WIDTH-bit universal shift register with a burst engine that repeats one
//   latched operation burst_len times, reporting busy and a one-cycle done.
//   Ports:
//     clk           in  1      rising-edge clock
//     reset         in  1      asynchronous active-low reset
//     en            in  1      single operation this cycle (IDLE only)
//     mode          in  3      operation select
//     ser_in_lsb    in  1      serial bit into LSB on SHL
//     ser_in_msb    in  1      serial bit into MSB on SHR
//     parallel_in   in  WIDTH  data for LOAD
//     burst_start   in  1      start a burst (priority over en)
//     burst_len     in  CNT_W  number of operations in the burst
//     parallel_out  out WIDTH  register contents
//     ser_out_msb   out 1      parallel_out[WIDTH-1]
//     ser_out_lsb   out 1      parallel_out[0]
//     busy          out 1      burst in progress
//     done          out 1      one-cycle pulse after the final burst op
module universal_shift_register_n
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             ser_in_lsb,
   input  logic             ser_in_msb,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] parallel_out,
   output logic             ser_out_msb,
   output logic             ser_out_lsb,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_lat_q, mode_lat_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [2:0]       unit_mode;
   logic [WIDTH-1:0] shifted;

   // One shared shift unit: live mode in IDLE, latched mode during a burst.
   assign unit_mode = (state_q == ST_BURST) ? mode_lat_q : mode;

   usr_shift_unit #(.WIDTH(WIDTH)) u_shift (
      .q           (data_q),
      .mode        (unit_mode),
      .ser_in_lsb  (ser_in_lsb),
      .ser_in_msb  (ser_in_msb),
      .parallel_in (parallel_in),
      .next_q      (shifted)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_lat_d = mode_lat_q;
      data_d     = data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (burst_start) begin
               if (burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  // First op of the burst happens at the accepting edge;
                  // cnt holds the number of ops still to come.
                  mode_lat_d = mode;
                  data_d     = shifted;
                  cnt_d      = burst_len - CNT_W'(1);
                  if (burst_len == CNT_W'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = ST_BURST;
                     busy_d  = 1'b1;
                  end
               end
            end else if (en) begin
               data_d = shifted;
            end
         end
         ST_BURST: begin
            data_d = shifted;
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         mode_lat_q <= MODE_HOLD;
         data_q     <= RESET_VAL;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_lat_q <= mode_lat_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign parallel_out = data_q;
   assign ser_out_msb  = data_q[WIDTH-1];
   assign ser_out_lsb  = data_q[0];
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
module tb_universal_shift_register_n;

   localparam int W  = 8;
   localparam int CW = 4;

   localparam logic [2:0] M_HOLD = 3'b000, M_SHL = 3'b001, M_SHR = 3'b010,
                          M_LOAD = 3'b011, M_ROTL = 3'b100, M_ROTR = 3'b101,
                          M_ASR = 3'b110, M_RSVD = 3'b111;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [2:0]    mode;
   logic          ser_in_lsb;
   logic          ser_in_msb;
   logic [W-1:0]  parallel_in;
   logic          burst_start;
   logic [CW-1:0] burst_len;
   logic [W-1:0]  parallel_out;
   logic          ser_out_msb;
   logic          ser_out_lsb;
   logic          busy;
   logic          done;

   universal_shift_register_n #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(8'h00)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .mode         (mode),
      .ser_in_lsb   (ser_in_lsb),
      .ser_in_msb   (ser_in_msb),
      .parallel_in  (parallel_in),
      .burst_start  (burst_start),
      .burst_len    (burst_len),
      .parallel_out (parallel_out),
      .ser_out_msb  (ser_out_msb),
      .ser_out_lsb  (ser_out_lsb),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_now(input string tag, input logic [W-1:0] q, input logic b, input logic d);
      chk({tag, ".q"}, 32'(parallel_out), 32'(q));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".done"}, 32'(done), 32'(d));
      $display("txn %-12s q=%h busy=%b done=%b (exp q=%h busy=%b done=%b)",
               tag, parallel_out, busy, done, q, b, d);
   endtask

   // Push the expected post-edge state, clock once, then pop and compare.
   task automatic step(input string tag, input logic [W-1:0] q, input logic b, input logic d);
      exp_t e;
      e.tag = tag; e.q = q; e.busy = b; e.done = d;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk_now(e.tag, e.q, e.busy, e.done);
         chk({e.tag, ".sout"}, 32'({ser_out_msb, ser_out_lsb}), 32'({e.q[W-1], e.q[0]}));
      end
   endtask

   task automatic load(input logic [W-1:0] v);
      en = 1'b1; mode = M_LOAD; parallel_in = v;
      step("load", v, 1'b0, 1'b0);
      en = 1'b0; mode = M_HOLD;
   endtask

   logic [2:0]   op_mode [8];
   logic         op_sl   [8];
   logic [W-1:0] op_exp  [8];

   initial begin
      op_mode[0] = M_SHL;  op_sl[0] = 1'b0; op_exp[0] = 8'hCA;
      op_mode[1] = M_SHR;  op_sl[1] = 1'b0; op_exp[1] = 8'h72;
      op_mode[2] = M_ROTL; op_sl[2] = 1'b0; op_exp[2] = 8'hCB;
      op_mode[3] = M_ROTR; op_sl[3] = 1'b0; op_exp[3] = 8'hF2;
      op_mode[4] = M_ASR;  op_sl[4] = 1'b0; op_exp[4] = 8'hF2;
      op_mode[5] = M_SHL;  op_sl[5] = 1'b1; op_exp[5] = 8'hCB;
      op_mode[6] = M_HOLD; op_sl[6] = 1'b0; op_exp[6] = 8'hE5;
      op_mode[7] = M_RSVD; op_sl[7] = 1'b0; op_exp[7] = 8'hE5;

      reset = 1'b0; en = 1'b0; mode = M_HOLD; ser_in_lsb = 1'b0; ser_in_msb = 1'b0;
      parallel_in = '0; burst_start = 1'b0; burst_len = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_now("reset_state", 8'h00, 1'b0, 1'b0);
      reset = 1'b1;

      // Asynchronous reset mid-cycle from E5
      load(8'hE5);
      #3 reset = 1'b0;
      #1 chk_now("async_reset", 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Single operations from E5
      for (int i = 0; i < 8; i++) begin
         load(8'hE5);
         en = 1'b1; mode = op_mode[i]; ser_in_lsb = op_sl[i]; ser_in_msb = 1'b0;
         step($sformatf("single_%0d", i), op_exp[i], 1'b0, 1'b0);
         en = 1'b0; ser_in_lsb = 1'b0;
      end

      // en low holds the value regardless of mode
      mode = M_SHL;
      step("en_low_hold", 8'hE5, 1'b0, 1'b0);

      // ROTL burst of 4 from E5, mode toggled mid-burst
      load(8'hE5);
      burst_start = 1'b1; mode = M_ROTL; burst_len = 4'd4;
      step("rotl_e0", 8'hCB, 1'b1, 1'b0);
      burst_start = 1'b0; mode = M_SHR;
      step("rotl_e1", 8'h97, 1'b1, 1'b0);
      mode = M_LOAD; parallel_in = 8'h00; en = 1'b1;
      step("rotl_e2", 8'h2F, 1'b1, 1'b0);
      mode = M_ASR;
      step("rotl_e3", 8'h5E, 1'b0, 1'b1);
      en = 1'b0; mode = M_HOLD;
      step("rotl_after", 8'h5E, 1'b0, 1'b0);

      // Zero-length burst
      burst_start = 1'b1; mode = M_SHL; burst_len = 4'd0;
      step("len0_e0", 8'h5E, 1'b0, 1'b1);
      burst_start = 1'b0; mode = M_HOLD;
      step("len0_after", 8'h5E, 1'b0, 1'b0);

      // Length-1 SHR burst from 80
      load(8'h80);
      burst_start = 1'b1; mode = M_SHR; burst_len = 4'd1; ser_in_msb = 1'b0;
      step("len1_e0", 8'h40, 1'b0, 1'b1);
      burst_start = 1'b0; mode = M_HOLD;
      step("len1_after", 8'h40, 1'b0, 1'b0);

      // burst_start and en together: burst wins; burst_start while busy ignored
      load(8'hE5);
      burst_start = 1'b1; en = 1'b1; mode = M_SHL; burst_len = 4'd2;
      step("prio_e0", 8'hCA, 1'b1, 1'b0);
      en = 1'b0; mode = M_ROTR; burst_len = 4'd3;
      step("prio_e1", 8'h94, 1'b0, 1'b1);
      burst_start = 1'b0; mode = M_HOLD;
      step("prio_after", 8'h94, 1'b0, 1'b0);
      step("prio_nodone", 8'h94, 1'b0, 1'b0);

      // LOAD burst follows the live parallel_in
      burst_start = 1'b1; mode = M_LOAD; burst_len = 4'd2; parallel_in = 8'hAA;
      step("ldb_e0", 8'hAA, 1'b1, 1'b0);
      burst_start = 1'b0; mode = M_HOLD; parallel_in = 8'h55;
      step("ldb_e1", 8'h55, 1'b0, 1'b1);

      // Reset during an SHL burst of 6 after op 3
      load(8'h01);
      burst_start = 1'b1; mode = M_SHL; burst_len = 4'd6; ser_in_lsb = 1'b1;
      step("abort_e0", 8'h03, 1'b1, 1'b0);
      burst_start = 1'b0; mode = M_HOLD;
      step("abort_e1", 8'h07, 1'b1, 1'b0);
      step("abort_e2", 8'h0F, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1 chk_now("abort_rst", 8'h00, 1'b0, 1'b0);
      step("abort_held", 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      step("abort_idle", 8'h00, 1'b0, 1'b0);
      en = 1'b1; mode = M_SHL; ser_in_lsb = 1'b1;
      step("resume_shl", 8'h01, 1'b0, 1'b0);
      step("resume_shl2", 8'h03, 1'b0, 1'b0);
      en = 1'b0; mode = M_HOLD; ser_in_lsb = 1'b0;
      step("resume_idle", 8'h03, 1'b0, 1'b0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
